// File: rtl/sched_pkg.sv
// rtl/sched_pkg.sv - command encodings, bank state and timing helpers for bank_cmd_scheduler
package sched_pkg;

  typedef enum logic [1:0] {
    CMD_ACT = 2'd0,
    CMD_RD  = 2'd1,
    CMD_WR  = 2'd2,
    CMD_PRE = 2'd3
  } cmd_e;

  typedef enum logic {
    BANK_IDLE   = 1'b0,
    BANK_ACTIVE = 1'b1
  } bank_state_e;

  localparam int N_TMR  = 5;
  localparam int TI_RCD = 0;
  localparam int TI_RAS = 1;
  localparam int TI_RP  = 2;
  localparam int TI_RTP = 3;
  localparam int TI_WR  = 4;

  function automatic int ceil_div(input int num, input int den);
    return (num + den - 1) / den;
  endfunction

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/bank_cmd_scheduler_if.sv
// rtl/bank_cmd_scheduler_if.sv - request handshake and issued-command bundle for bank_cmd_scheduler
interface bank_cmd_scheduler_if #(
  parameter int nCK_PER_CLK = 4,
  parameter int NBANKS      = 8,
  parameter int ADDR_W      = 17
);
  localparam int BANK_W = $clog2(NBANKS);
  localparam int SLOT_W = $clog2(nCK_PER_CLK);

  logic              req_valid_i;
  logic              req_ready_o;
  logic [1:0]        req_cmd_i;
  logic [BANK_W-1:0] req_bank_i;
  logic [ADDR_W-1:0] req_addr_i;
  logic              cmd_valid_o;
  logic [1:0]        cmd_o;
  logic [BANK_W-1:0] cmd_bank_o;
  logic [ADDR_W-1:0] cmd_addr_o;
  logic [SLOT_W-1:0] cmd_slot_o;
  logic              err_o;
  logic [NBANKS-1:0] bank_open_o;

  modport master (
    output req_valid_i, req_cmd_i, req_bank_i, req_addr_i,
    input  req_ready_o, cmd_valid_o, cmd_o, cmd_bank_o, cmd_addr_o, cmd_slot_o, err_o, bank_open_o
  );

  modport slave (
    input  req_valid_i, req_cmd_i, req_bank_i, req_addr_i,
    output req_ready_o, cmd_valid_o, cmd_o, cmd_bank_o, cmd_addr_o, cmd_slot_o, err_o, bank_open_o
  );

endinterface

// File: rtl/bank_timer.sv
// rtl/bank_timer.sv - one per-bank DDR timing counter, in DDR clocks relative to the next fabric cycle
module bank_timer #(
  parameter int NCK    = 4,
  parameter int T      = 6,
  parameter int TMR_W  = 5,
  parameter int SLOT_W = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load_i,
  input  logic [SLOT_W-1:0] slot_i,
  output logic [TMR_W-1:0]  val_o,
  output logic              pass_o
);

  localparam logic [TMR_W-1:0] NCK_V = TMR_W'(NCK);

  logic [TMR_W-1:0] val_q, val_d;

  // Value is the first legal slot of the current fabric cycle; a whole cycle retires NCK clocks.
  always_comb begin
    val_d = (val_q < NCK_V) ? '0 : val_q - NCK_V;
    if (load_i) begin
      val_d = (T + int'(slot_i) > NCK) ? TMR_W'(T + int'(slot_i) - NCK) : '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) val_q <= '0;
    else        val_q <= val_d;
  end

  assign val_o  = val_q;
  assign pass_o = (val_q < NCK_V);

endmodule

// File: rtl/bank_cmd_scheduler.sv
// rtl/bank_cmd_scheduler.sv - per-bank DDR timing gate issuing ACT/RD/WR/PRE in the earliest legal slot
// BANK_SCHED_STATS_EN adds stall_cycles_o / issued_o counters.
module bank_cmd_scheduler
  import sched_pkg::*;
#(
  parameter int nCK_PER_CLK = 4,
  parameter int NBANKS      = 8,
  parameter int ADDR_W      = 17,
  parameter int TCK_PS      = 2500,
  parameter int TRCD_PS     = 13750,
  parameter int TRAS_PS     = 35000,
  parameter int TRP_PS      = 13750,
  parameter int TRTP_PS     = 7500,
  parameter int TWR_PS      = 15000
) (
  input  logic        clk,
  input  logic        rst_n,
`ifdef BANK_SCHED_STATS_EN
  output logic [31:0] stall_cycles_o,
  output logic [31:0] issued_o,
`endif
  bank_cmd_scheduler_if.slave bus
);

  localparam int BANK_W = $clog2(NBANKS);
  localparam int SLOT_W = $clog2(nCK_PER_CLK);
  localparam int T_RCD  = ceil_div(TRCD_PS, TCK_PS);
  localparam int T_RAS  = ceil_div(TRAS_PS, TCK_PS);
  localparam int T_RP   = ceil_div(TRP_PS, TCK_PS);
  localparam int T_RTP  = ceil_div(TRTP_PS, TCK_PS);
  localparam int T_WR   = ceil_div(TWR_PS, TCK_PS);
  localparam int T_MAX  = max_int(max_int(T_RCD, T_RAS), max_int(T_RP, max_int(T_RTP, T_WR)));
  localparam int TMR_W  = $clog2(T_MAX + nCK_PER_CLK);

  function automatic int t_of(input int k);
    case (k)
      TI_RCD:  return T_RCD;
      TI_RAS:  return T_RAS;
      TI_RP:   return T_RP;
      TI_RTP:  return T_RTP;
      default: return T_WR;
    endcase
  endfunction

  function automatic logic loads_on(input int k, input logic [1:0] c);
    case (k)
      TI_RCD, TI_RAS: return c == CMD_ACT;
      TI_RP:          return c == CMD_PRE;
      TI_RTP:         return c == CMD_RD;
      default:        return c == CMD_WR;
    endcase
  endfunction

  logic [TMR_W-1:0]  tmr_val  [NBANKS][N_TMR];
  logic              tmr_pass [NBANKS][N_TMR];
  logic              tmr_load [NBANKS][N_TMR];
  bank_state_e       state_q  [NBANKS];
  bank_state_e       state_d  [NBANKS];
  logic              cmd_valid_q, cmd_valid_d, err_q, err_d;
  logic [1:0]        cmd_q, cmd_d;
  logic [BANK_W-1:0] bank_q, bank_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [SLOT_W-1:0] slot_q, slot_d;
  logic [BANK_W-1:0] hb;
  logic [TMR_W-1:0]  gate_val;
  logic [SLOT_W-1:0] issue_slot;
  logic              legal, gate_pass, issue_en, reject;

  assign hb         = bus.req_bank_i;
  assign issue_slot = gate_val[SLOT_W-1:0];

  for (genvar b = 0; b < NBANKS; b++) begin : g_bank
    for (genvar k = 0; k < N_TMR; k++) begin : g_tmr
      assign tmr_load[b][k] = issue_en && (hb == BANK_W'(b)) && loads_on(k, bus.req_cmd_i);
      bank_timer #(
        .NCK(nCK_PER_CLK), .T(t_of(k)), .TMR_W(TMR_W), .SLOT_W(SLOT_W)
      ) u_tmr (
        .clk(clk), .rst_n(rst_n), .load_i(tmr_load[b][k]), .slot_i(issue_slot),
        .val_o(tmr_val[b][k]), .pass_o(tmr_pass[b][k])
      );
    end
    assign bus.bank_open_o[b] = (state_q[b] == BANK_ACTIVE);
  end

  // The gate slot is the latest of the relevant timers; it is issuable when it fits this cycle.
  always_comb begin
    legal = (bus.req_cmd_i == CMD_ACT) ? (state_q[hb] == BANK_IDLE) : (state_q[hb] == BANK_ACTIVE);
    gate_val  = '0;
    gate_pass = 1'b0;
    case (bus.req_cmd_i)
      CMD_ACT: begin
        gate_val  = tmr_val[hb][TI_RP];
        gate_pass = tmr_pass[hb][TI_RP];
      end
      CMD_RD, CMD_WR: begin
        gate_val  = tmr_val[hb][TI_RCD];
        gate_pass = tmr_pass[hb][TI_RCD];
      end
      default: begin
        gate_val = tmr_val[hb][TI_RAS];
        if (tmr_val[hb][TI_RTP] > gate_val) gate_val = tmr_val[hb][TI_RTP];
        if (tmr_val[hb][TI_WR] > gate_val)  gate_val = tmr_val[hb][TI_WR];
        gate_pass = tmr_pass[hb][TI_RAS] & tmr_pass[hb][TI_RTP] & tmr_pass[hb][TI_WR];
      end
    endcase
    issue_en = bus.req_valid_i & legal & gate_pass;
    reject   = bus.req_valid_i & ~legal;
  end

  assign bus.req_ready_o = issue_en | reject;

  always_comb begin
    state_d     = state_q;
    cmd_valid_d = issue_en;
    err_d       = reject;
    cmd_d       = cmd_q;
    bank_d      = bank_q;
    addr_d      = addr_q;
    slot_d      = slot_q;
    if (issue_en) begin
      cmd_d  = bus.req_cmd_i;
      bank_d = hb;
      addr_d = bus.req_addr_i;
      slot_d = issue_slot;
      if (bus.req_cmd_i == CMD_ACT)      state_d[hb] = BANK_ACTIVE;
      else if (bus.req_cmd_i == CMD_PRE) state_d[hb] = BANK_IDLE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int b = 0; b < NBANKS; b++) state_q[b] <= BANK_IDLE;
      cmd_valid_q <= 1'b0;
      err_q       <= 1'b0;
      cmd_q       <= '0;
      bank_q      <= '0;
      addr_q      <= '0;
      slot_q      <= '0;
    end else begin
      state_q     <= state_d;
      cmd_valid_q <= cmd_valid_d;
      err_q       <= err_d;
      cmd_q       <= cmd_d;
      bank_q      <= bank_d;
      addr_q      <= addr_d;
      slot_q      <= slot_d;
    end
  end

  assign bus.cmd_valid_o = cmd_valid_q;
  assign bus.err_o       = err_q;
  assign bus.cmd_o       = cmd_q;
  assign bus.cmd_bank_o  = bank_q;
  assign bus.cmd_addr_o  = addr_q;
  assign bus.cmd_slot_o  = slot_q;

`ifdef BANK_SCHED_STATS_EN
  logic [31:0] stall_q, stall_d, issued_q, issued_d;

  always_comb begin
    stall_d  = stall_q + 32'(bus.req_valid_i & ~bus.req_ready_o);
    issued_d = issued_q + 32'(issue_en);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_q  <= '0;
      issued_q <= '0;
    end else begin
      stall_q  <= stall_d;
      issued_q <= issued_d;
    end
  end

  assign stall_cycles_o = stall_q;
  assign issued_o       = issued_q;
`endif

endmodule

// File: tb/tb_bank_cmd_scheduler.sv
// tb/tb_bank_cmd_scheduler.sv - directed table, reset sequence and randomized model check of bank_cmd_scheduler
module tb_bank_cmd_scheduler;
  import sched_pkg::*;

  localparam int NCK = 4, NB = 8, AW = 17, BW = 3;
  localparam int T_RCD = 6, T_RAS = 14, T_RP = 6, T_RTP = 3, T_WR = 6;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  bank_cmd_scheduler_if bus ();
`ifdef BANK_SCHED_STATS_EN
  logic [31:0] stall_cycles, issued;
`endif

  bank_cmd_scheduler dut (
    .clk(clk),
    .rst_n(rst_n),
`ifdef BANK_SCHED_STATS_EN
    .stall_cycles_o(stall_cycles),
    .issued_o(issued),
`endif
    .bus(bus)
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: earliest legal absolute DDR clock per bank and command class.
  longint cyc;
  longint e_act [NB], e_rw [NB], e_pre [NB];
  bit     m_open [NB];
  bit     x_cv, x_err;
  logic [1:0]    x_cmd;
  logic [BW-1:0] x_bank;
  logic [AW-1:0] x_addr;
  logic [1:0]    x_slot;
  longint x_stall, x_issued;

  task automatic model_reset();
    for (int i = 0; i < NB; i++) begin
      e_act[i] = 0; e_rw[i] = 0; e_pre[i] = 0; m_open[i] = 0;
    end
    x_cv = 0; x_err = 0; x_cmd = '0; x_bank = '0; x_addr = '0; x_slot = '0;
    x_stall = 0; x_issued = 0;
  endtask

  function automatic longint lmax(input longint a, input longint b);
    return (a > b) ? a : b;
  endfunction

  task automatic check_outputs();
    logic [NB-1:0] om;
    for (int i = 0; i < NB; i++) om[i] = m_open[i];
    chk("cmd_valid", 64'(bus.cmd_valid_o), 64'(x_cv));
    chk("err", 64'(bus.err_o), 64'(x_err));
    chk("cmd", 64'(bus.cmd_o), 64'(x_cmd));
    chk("cmd_bank", 64'(bus.cmd_bank_o), 64'(x_bank));
    chk("cmd_addr", 64'(bus.cmd_addr_o), 64'(x_addr));
    chk("cmd_slot", 64'(bus.cmd_slot_o), 64'(x_slot));
    chk("bank_open", 64'(bus.bank_open_o), 64'(om));
`ifdef BANK_SCHED_STATS_EN
    chk("stall_cycles", 64'(stall_cycles), 64'(x_stall[31:0]));
    chk("issued", 64'(issued), 64'(x_issued[31:0]));
`endif
  endtask

  task automatic put(input bit v, input logic [1:0] c, input int b, input logic [AW-1:0] a);
    bus.req_valid_i = v;
    bus.req_cmd_i   = c;
    bus.req_bank_i  = BW'(b);
    bus.req_addr_i  = a;
  endtask

  task automatic drive(input bit v, input logic [1:0] c, input int b, input logic [AW-1:0] a,
                       output bit rdy);
    bit legal;
    longint e, base, slot, t;
    @(negedge clk);
    check_outputs();
    put(v, c, b, a);
    legal = (c == CMD_ACT) ? !m_open[b] : m_open[b];
    e     = (c == CMD_ACT) ? e_act[b] : (c == CMD_PRE) ? e_pre[b] : e_rw[b];
    base  = (cyc + 1) * NCK;
    slot  = (e > base) ? e - base : 0;
    rdy   = v && (!legal || slot < NCK);
    #1;
    chk("ready", 64'(bus.req_ready_o), 64'(rdy));
    x_cv = 0; x_err = 0;
    if (v && !legal) begin
      x_err = 1;
    end else if (rdy) begin
      x_cv = 1; x_cmd = c; x_bank = BW'(b); x_addr = a; x_slot = 2'(slot);
      x_issued++;
      t = base + slot;
      case (c)
        CMD_ACT: begin m_open[b] = 1; e_rw[b] = t + T_RCD; e_pre[b] = lmax(e_pre[b], t + T_RAS); end
        CMD_RD:  e_pre[b] = lmax(e_pre[b], t + T_RTP);
        CMD_WR:  e_pre[b] = lmax(e_pre[b], t + T_WR);
        default: begin m_open[b] = 0; e_act[b] = t + T_RP; end
      endcase
    end
    if (v && !rdy) x_stall++;
    cyc++;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    bus.req_valid_i = 1'b0;
    @(negedge clk);
    model_reset();
    rst_n = 1'b1;
  endtask

  typedef struct {
    bit            v;
    logic [1:0]    c;
    int            b;
    logic [AW-1:0] a;
    bit            rdy;
    bit            cv;
    bit            err;
    logic [1:0]    slot;
    logic [NB-1:0] open;
  } vec_t;

  localparam int NTBL = 14;
  vec_t tbl [NTBL];

  task automatic chk_row(input int j);
    chk($sformatf("tbl%0d_cmd_valid", j), 64'(bus.cmd_valid_o), 64'(tbl[j].cv));
    chk($sformatf("tbl%0d_err", j), 64'(bus.err_o), 64'(tbl[j].err));
    chk($sformatf("tbl%0d_bank_open", j), 64'(bus.bank_open_o), 64'(tbl[j].open));
    if (tbl[j].cv) begin
      chk($sformatf("tbl%0d_slot", j), 64'(bus.cmd_slot_o), 64'(tbl[j].slot));
      chk($sformatf("tbl%0d_cmd", j), 64'(bus.cmd_o), 64'(tbl[j].c));
      chk($sformatf("tbl%0d_addr", j), 64'(bus.cmd_addr_o), 64'(tbl[j].a));
    end
  endtask

  bit cur_v, rdy_prev;
  logic [1:0] cur_c;
  int cur_b;
  logic [AW-1:0] cur_a;

  initial begin
    //              v  cmd      bk addr      rdy cv err slot open
    tbl[0]  = '{1, CMD_ACT, 0, 17'h00100, 1, 1, 0, 2'd0, 8'h01};
    tbl[1]  = '{1, CMD_RD,  0, 17'h00020, 1, 1, 0, 2'd2, 8'h01};
    tbl[2]  = '{1, CMD_ACT, 1, 17'h00200, 1, 1, 0, 2'd0, 8'h03};
    tbl[3]  = '{1, CMD_PRE, 1, 17'h00000, 0, 0, 0, 2'd0, 8'h03};
    tbl[4]  = '{1, CMD_PRE, 1, 17'h00000, 0, 0, 0, 2'd0, 8'h03};
    tbl[5]  = '{1, CMD_PRE, 1, 17'h00000, 1, 1, 0, 2'd2, 8'h01};
    tbl[6]  = '{1, CMD_ACT, 1, 17'h00300, 0, 0, 0, 2'd0, 8'h01};
    tbl[7]  = '{1, CMD_ACT, 1, 17'h00300, 1, 1, 0, 2'd0, 8'h03};
    tbl[8]  = '{1, CMD_RD,  3, 17'h00011, 1, 0, 1, 2'd0, 8'h03};
    tbl[9]  = '{1, CMD_ACT, 0, 17'h00022, 1, 0, 1, 2'd0, 8'h03};
    tbl[10] = '{1, CMD_PRE, 0, 17'h00000, 1, 1, 0, 2'd0, 8'h02};
    tbl[11] = '{1, CMD_WR,  1, 17'h00040, 1, 1, 0, 2'd0, 8'h02};
    tbl[12] = '{1, CMD_PRE, 1, 17'h00000, 1, 1, 0, 2'd2, 8'h00};
    tbl[13] = '{0, CMD_ACT, 2, 17'h00000, 0, 0, 0, 2'd0, 8'h00};

    cyc = 0;
    rst_n = 1'b0;
    put(0, CMD_ACT, 0, '0);
    model_reset();
    #2;
    check_outputs();
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < NTBL; i++) begin
      @(negedge clk);
      if (i > 0) chk_row(i - 1);
`ifdef BANK_SCHED_STATS_EN
      if (i == 6) begin
        chk("stats_stall_after_pre", 64'(stall_cycles), 64'd2);
        chk("stats_issued_after_pre", 64'(issued), 64'd4);
      end
`endif
      put(tbl[i].v, tbl[i].c, tbl[i].b, tbl[i].a);
      #1 chk($sformatf("tbl%0d_ready", i), 64'(bus.req_ready_o), 64'(tbl[i].rdy));
    end
    @(negedge clk);
    chk_row(NTBL - 1);

    // ACT b5 stalled on rp, then asynchronous reset in the middle of the stall
    do_reset();
    @(negedge clk); put(1, CMD_ACT, 5, 17'h55);
    #1 chk("rst_seq_act_ready", 64'(bus.req_ready_o), 64'd1);
    @(negedge clk); put(0, CMD_ACT, 0, '0);
    @(negedge clk);
    @(negedge clk); put(1, CMD_PRE, 5, '0);
    #1 chk("rst_seq_pre_ready", 64'(bus.req_ready_o), 64'd1);
    @(negedge clk);
    chk("rst_seq_pre_valid", 64'(bus.cmd_valid_o), 64'd1);
    chk("rst_seq_pre_slot", 64'(bus.cmd_slot_o), 64'd2);
    put(1, CMD_ACT, 5, 17'h66);
    #1 chk("rst_seq_act_stall", 64'(bus.req_ready_o), 64'd0);
    #1 rst_n = 1'b0;
    #1;
    chk("rst_async_valid", 64'(bus.cmd_valid_o), 64'd0);
    chk("rst_async_cmd", 64'(bus.cmd_o), 64'd0);
    chk("rst_async_bank", 64'(bus.cmd_bank_o), 64'd0);
    chk("rst_async_slot", 64'(bus.cmd_slot_o), 64'd0);
    chk("rst_async_open", 64'(bus.bank_open_o), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    put(1, CMD_ACT, 0, 17'h77);
    #1 chk("post_rst_act_ready", 64'(bus.req_ready_o), 64'd1);
    @(negedge clk);
    chk("post_rst_act_valid", 64'(bus.cmd_valid_o), 64'd1);
    chk("post_rst_act_slot", 64'(bus.cmd_slot_o), 64'd0);
    chk("post_rst_act_addr", 64'(bus.cmd_addr_o), 64'h77);
    chk("post_rst_open", 64'(bus.bank_open_o), 64'h01);
    put(0, CMD_ACT, 0, '0);

    // Randomized traffic on a few banks; a stalled request is held until accepted
    do_reset();
    rdy_prev = 1;
    cur_v = 0; cur_c = '0; cur_b = 0; cur_a = '0;
    for (int i = 0; i < 3000; i++) begin
      if (i == 1500) do_reset();
      if (!cur_v || rdy_prev) begin
        cur_v = ($urandom_range(0, 3) != 0);
        cur_c = 2'($urandom_range(0, 3));
        cur_b = $urandom_range(0, 3);
        cur_a = AW'($urandom);
      end
      drive(cur_v, cur_c, cur_b, cur_a, rdy_prev);
    end
    @(negedge clk);
    check_outputs();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
